cube_state_scanner: RTL and testbench

// Parametrised successor of the single-sensor cube state capture FSM. Steps through NUM_STICKERS
// non-centre stickers, requesting one positioning move per sticker from the move sequencer.

---
 rtl/cube_state_scanner.sv | 183 ++++++++++++++++++
 tb/tb_cube_state_scanner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_state_scanner.sv
// Cube state scanner: asks the move sequencer to present each non-centre sticker in turn, takes a
// majority vote from the corner or edge colour sensor, then checks per-colour counts before release.
//
// state   | meaning
// IDLE    | waiting for start after reset
// REQ     | one-cycle move request for sticker move_idx (move_idx=NUM_STICKERS is the restore move)
// WAIT    | waiting for move_done from the sequencer
// SETTLE  | sensor settling after the move, votes ignored
// VOTE    | collecting SAMPLES votes per round, retrying rounds without a majority
// CHECK   | one sticker per cycle colour-count pass
// DONE    | result held until the next start
module cube_state_scanner #(
  parameter int COLOR_W      = 3,
  parameter int NUM_COLORS   = 6,
  parameter int NUM_STICKERS = 48,
  parameter int CORNER_STK   = 24,
  parameter int SAMPLES      = 3,
  parameter int SETTLE_CYC   = 4,
  parameter int MAX_RETRY    = 2,
  parameter logic [NUM_COLORS*COLOR_W-1:0] CENTERS = 18'h2C688
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [COLOR_W-1:0]                          corner_color,
  input  logic [COLOR_W-1:0]                          edge_color,
  input  logic                                        color_valid,
  input  logic                                        move_done,
  output logic                                        move_req,
  output logic [5:0]                                  move_idx,
  output logic [(NUM_STICKERS+NUM_COLORS)*COLOR_W-1:0] cube_state,
  output logic                                        state_valid,
  output logic                                        state_error,
  output logic                                        busy
);

  localparam int CNT_W = $clog2(SAMPLES + 1);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CHK_W = $clog2(NUM_STICKERS + 1);
  localparam logic [5:0] RESTORE_IDX = 6'(NUM_STICKERS);
  localparam logic [5:0] CORNER_IDX  = 6'(CORNER_STK);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_SETTLE, S_VOTE, S_CHECK, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [COLOR_W-1:0] stickers [NUM_STICKERS];
  logic [CNT_W-1:0]   vote_cnt [NUM_COLORS];
  logic [CNT_W-1:0]   vote_nxt [NUM_COLORS];
  logic [CHK_W-1:0]   chk_cnt  [NUM_COLORS];
  logic [CHK_W-1:0]   chk_nxt  [NUM_COLORS];
  logic [CNT_W-1:0]   slot_cnt;
  logic [RTY_W-1:0]   retry_cnt;
  logic [SET_W-1:0]   settle_cnt;
  logic [5:0]         chk_idx;

  logic [COLOR_W-1:0] sample;
  logic [COLOR_W-1:0] chk_color;
  logic [COLOR_W-1:0] win_color;
  logic               vote_hit;
  logic               vote_last;
  logic               win_found;
  logic               chk_pass;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sample    = (move_idx < CORNER_IDX) ? corner_color : edge_color;
    chk_color = stickers[chk_idx];
    vote_hit  = (state == S_VOTE) && color_valid;
    vote_last = vote_hit && (slot_cnt == CNT_W'(SAMPLES - 1));
    win_found = 1'b0;
    win_color = '0;
    chk_pass  = 1'b1;
    // Invalid codes match no colour, so they use up a slot without adding a count.
    for (int c = 0; c < NUM_COLORS; c++) begin
      vote_nxt[c] = vote_cnt[c] + CNT_W'(vote_hit && (sample == COLOR_W'(c)));
      chk_nxt[c]  = chk_cnt[c] + CHK_W'((state == S_CHECK) && (chk_color == COLOR_W'(c)));
      if (vote_nxt[c] >= CNT_W'(SAMPLES / 2 + 1)) begin
        win_found = 1'b1;
        win_color = COLOR_W'(c);
      end
      if (chk_nxt[c] != CHK_W'(NUM_STICKERS / NUM_COLORS)) chk_pass = 1'b0;
    end

    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_REQ;
      S_REQ:          state_nxt = S_WAIT;
      S_WAIT:
        if (move_done) state_nxt = (move_idx == RESTORE_IDX) ? S_CHECK : S_SETTLE;
      S_SETTLE:       if (settle_cnt == '0) state_nxt = S_VOTE;
      S_VOTE:
        if (vote_last) begin
          if (win_found)                          state_nxt = S_REQ;
          else if (retry_cnt == RTY_W'(MAX_RETRY)) state_nxt = S_DONE;
        end
      S_CHECK:        if (chk_idx == '0) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      move_idx    <= '0;
      state_valid <= 1'b0;
      state_error <= 1'b0;
      slot_cnt    <= '0;
      retry_cnt   <= '0;
      settle_cnt  <= '0;
      chk_idx     <= '0;
      for (int i = 0; i < NUM_STICKERS; i++) stickers[i] <= '0;
      for (int c = 0; c < NUM_COLORS; c++) begin
        vote_cnt[c] <= '0;
        chk_cnt[c]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE, S_DONE:
          if (start) begin
            move_idx    <= '0;
            state_valid <= 1'b0;
            state_error <= 1'b0;
            slot_cnt    <= '0;
            retry_cnt   <= '0;
            for (int i = 0; i < NUM_STICKERS; i++) stickers[i] <= '0;
            for (int c = 0; c < NUM_COLORS; c++) vote_cnt[c] <= '0;
          end
        S_WAIT:
          if (move_done) begin
            settle_cnt <= SET_W'(SETTLE_CYC - 1);
            chk_idx    <= 6'(NUM_STICKERS - 1);
            for (int c = 0; c < NUM_COLORS; c++) chk_cnt[c] <= '0;
          end
        S_SETTLE:
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SET_W'(1);
        S_VOTE:
          if (vote_last) begin
            slot_cnt <= '0;
            for (int c = 0; c < NUM_COLORS; c++) vote_cnt[c] <= '0;
            if (win_found) begin
              stickers[move_idx] <= win_color;
              retry_cnt          <= '0;
              // Past the last sticker this lands on the restore-move index.
              move_idx           <= move_idx + 6'd1;
            end else if (retry_cnt == RTY_W'(MAX_RETRY)) begin
              state_error <= 1'b1;
            end else begin
              retry_cnt <= retry_cnt + RTY_W'(1);
            end
          end else if (vote_hit) begin
            slot_cnt <= slot_cnt + CNT_W'(1);
            for (int c = 0; c < NUM_COLORS; c++) vote_cnt[c] <= vote_nxt[c];
          end
        S_CHECK: begin
          for (int c = 0; c < NUM_COLORS; c++) chk_cnt[c] <= chk_nxt[c];
          chk_idx <= chk_idx - 6'd1;
          if (chk_idx == '0) begin
            state_valid <= chk_pass;
            state_error <= ~chk_pass;
          end
        end
        default: ;
      endcase
    end
  end

  assign move_req = (state == S_REQ);
  assign busy     = !((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    cube_state = '0;
    cube_state[(NUM_STICKERS+NUM_COLORS)*COLOR_W-1 -: NUM_COLORS*COLOR_W] = CENTERS;
    for (int i = 0; i < NUM_STICKERS; i++) cube_state[i*COLOR_W +: COLOR_W] = stickers[i];
  end

endmodule

// File: tb/tb_cube_state_scanner.sv
// Bench for cube_state_scanner: models the move sequencer and colour sensors, runs a table of
// scan scenarios and a few hand-written reset sequences against expected cube contents.
module tb_cube_state_scanner;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   corner_color;
  logic [2:0]   edge_color;
  logic         color_valid;
  logic         move_done;
  logic         move_req;
  logic [5:0]   move_idx;
  logic [161:0] cube_state;
  logic         state_valid;
  logic         state_error;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int mode     = 0;
  bit noise    = 0;
  bit mid_start = 0;

  cube_state_scanner dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .corner_color (corner_color),
    .edge_color   (edge_color),
    .color_valid  (color_valid),
    .move_done    (move_done),
    .move_req     (move_req),
    .move_idx     (move_idx),
    .cube_state   (cube_state),
    .state_valid  (state_valid),
    .state_error  (state_error),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int mode;
    bit noise;
    bit mid_start;
    int exp_req;
    int exp_idx;
    bit exp_valid;
    bit exp_error;
  } scen_t;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [161:0] act, input logic [161:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Solved-cube colour per sticker: 8 of each colour, sticker 5 is R.
  function automatic logic [2:0] solved(int i);
    return 3'((i + 4) % 6);
  endfunction

  function automatic logic [2:0] vote_val(int m, int idx, int vn);
    int slot  = vn % 3;
    int round = vn / 3;
    case (m)
      1: begin
        if (idx == 5)  return (slot == 2) ? 3'd2 : 3'd3;
        if (idx == 35) return (slot == 1) ? 3'd7 : 3'd3;
        if (idx == 11) return (round == 0) ? 3'(slot) : 3'd3;
        if (idx == 29) return (round < 2) ? 3'(slot) : 3'd3;
      end
      2: if (idx == 30) return 3'(slot);
      3: if (idx == 0) return 3'd5;
      default: ;
    endcase
    return solved(idx);
  endfunction

  function automatic logic [2:0] exp_color(int m, int i);
    if (m == 2 && i >= 30) return 3'd0;
    if (m == 3 && i == 0) return 3'd5;
    return solved(i);
  endfunction

  function automatic logic [161:0] exp_cube(int m);
    logic [161:0] r;
    r = '0;
    r[161:144] = 18'h2C688;
    for (int i = 0; i < 48; i++) r[i*3 +: 3] = exp_color(m, i);
    return r;
  endfunction

  task automatic run_scan(input int stop_at, output int n_req, output int consec,
                          output int idx_err, output bit stopped);
    int since_done, vote_no, cur_idx, done_at, exp_idx;
    logic [2:0] v, ot;
    bit prev_req;
    n_req = 0; consec = 0; idx_err = 0; stopped = 0; prev_req = 0;
    since_done = -1; vote_no = 0; cur_idx = 0; done_at = -1; exp_idx = 0;
    start = 1'b1;
    step();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      color_valid = 1'b0;
      move_done   = 1'b0;
      start       = 1'b0;
      if (move_req) begin
        n_req++;
        if (prev_req) consec++;
        if (int'(move_idx) != exp_idx) idx_err++;
        exp_idx++;
        cur_idx    = int'(move_idx);
        done_at    = 2;
        since_done = -1;
        vote_no    = 0;
      end
      prev_req = move_req;
      if (!busy) break;
      if (stop_at >= 0 && cur_idx == stop_at && since_done == 7) begin
        stopped = 1;
        break;
      end
      if (done_at == 0) begin
        move_done  = 1'b1;
        since_done = 0;
        done_at    = -1;
      end else if (done_at > 0) begin
        done_at--;
      end else if (since_done >= 0) begin
        since_done++;
        if (noise && since_done <= 4) begin
          corner_color = 3'((int'(solved(cur_idx)) + 2) % 6);
          edge_color   = corner_color;
          color_valid  = 1'b1;
        end else if (since_done >= 6 && since_done % 2 == 0) begin
          v  = vote_val(mode, cur_idx, vote_no);
          ot = (v == 3'd7) ? 3'd0 : 3'((int'(v) + 1) % 6);
          vote_no++;
          if (cur_idx < 24) begin corner_color = v;  edge_color = ot; end
          else              begin corner_color = ot; edge_color = v;  end
          color_valid = 1'b1;
        end
      end
      if (mid_start && cyc % 37 == 5) start = 1'b1;
      step();
    end
    color_valid = 1'b0;
    move_done   = 1'b0;
    start       = 1'b0;
  endtask

  scen_t tbl [5];
  int    n_req, consec, idx_err;
  bit    stopped;

  initial begin
    tbl[0] = '{0, 0, 0, 49, 48, 1, 0};
    tbl[1] = '{2, 0, 0, 31, 30, 0, 1};
    tbl[2] = '{1, 0, 0, 49, 48, 1, 0};
    tbl[3] = '{3, 0, 0, 49, 48, 0, 1};
    tbl[4] = '{0, 1, 1, 49, 48, 1, 0};

    reset = 1'b1; start = 1'b0; corner_color = '0; edge_color = '0;
    color_valid = 1'b0; move_done = 1'b0;
    repeat (3) step();
    check("rst_busy",   162'(busy), 162'(0));
    check("rst_req",    162'(move_req), 162'(0));
    check("rst_idx",    162'(move_idx), 162'(0));
    check("rst_valid",  162'(state_valid), 162'(0));
    check("rst_error",  162'(state_error), 162'(0));
    check("rst_cube",   cube_state, {18'h2C688, 144'd0});
    reset = 1'b0;
    step();
    check("idle_busy",  162'(busy), 162'(0));

    for (int k = 0; k < 5; k++) begin
      mode      = tbl[k].mode;
      noise     = tbl[k].noise;
      mid_start = tbl[k].mid_start;
      run_scan(-1, n_req, consec, idx_err, stopped);
      check($sformatf("s%0d_ended", k),   162'(busy), 162'(0));
      check($sformatf("s%0d_nreq", k),    162'(n_req), 162'(tbl[k].exp_req));
      check($sformatf("s%0d_consec", k),  162'(consec), 162'(0));
      check($sformatf("s%0d_idxseq", k),  162'(idx_err), 162'(0));
      check($sformatf("s%0d_idx", k),     162'(move_idx), 162'(tbl[k].exp_idx));
      // Strobes while DONE must not disturb the held result.
      for (int j = 0; j < 3; j++) begin
        color_valid = 1'b1;
        move_done   = 1'b1;
        corner_color = 3'd7;
        edge_color   = 3'd7;
        step();
      end
      color_valid = 1'b0;
      move_done   = 1'b0;
      check($sformatf("s%0d_held_req", k), 162'(move_req), 162'(0));
      check($sformatf("s%0d_valid", k),   162'(state_valid), 162'(tbl[k].exp_valid));
      check($sformatf("s%0d_error", k),   162'(state_error), 162'(tbl[k].exp_error));
      check($sformatf("s%0d_centres", k), 162'(cube_state[161:144]), 162'(18'h2C688));
      check($sformatf("s%0d_stk5", k),    162'(cube_state[17:15]), 162'(exp_color(mode, 5)));
      check($sformatf("s%0d_cube", k),    cube_state, exp_cube(mode));
    end

    mode = 0; noise = 0; mid_start = 0;
    run_scan(20, n_req, consec, idx_err, stopped);
    check("mid_stopped", 162'(stopped), 162'(1));
    check("mid_idx",     162'(move_idx), 162'(20));
    check("mid_busy",    162'(busy), 162'(1));
    reset = 1'b1;
    color_valid = 1'b1;
    move_done   = 1'b1;
    step();
    check("mrst_busy",  162'(busy), 162'(0));
    check("mrst_idx",   162'(move_idx), 162'(0));
    check("mrst_cube",  cube_state, {18'h2C688, 144'd0});
    reset = 1'b0;
    step();
    check("mrst_ignore_busy", 162'(busy), 162'(0));
    check("mrst_ignore_req",  162'(move_req), 162'(0));
    color_valid = 1'b0;
    move_done   = 1'b0;
    step();

    run_scan(-1, n_req, consec, idx_err, stopped);
    check("rescan_ended", 162'(busy), 162'(0));
    check("rescan_nreq",  162'(n_req), 162'(49));
    check("rescan_idx",   162'(idx_err), 162'(0));
    check("rescan_valid", 162'(state_valid), 162'(1));
    check("rescan_error", 162'(state_error), 162'(0));
    check("rescan_cube",  cube_state, exp_cube(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
